// File: rtl/layer_compositor.sv
// Layer compositor: border, platform/pit with hole, power bar and NUM_OBJ sprites into 12-bit VGA, 2-clock latency.
// Optional macro COMPOSITOR_RAND_FLASH_EN: flashing sprites use LFSR colours instead of blinking black.
module layer_compositor #(
   parameter int NUM_OBJ      = 4,
   parameter int OBJ_W        = 16,
   parameter int OBJ_H        = 16,
   parameter int BORDER       = 8,
   parameter int PLAT_Y       = 360,
   parameter int PLAT_H       = 20,
   parameter int BAR_X        = 32,
   parameter int BAR_BASE     = 96,
   parameter int FLASH_FRAMES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    frame_tick,
   input  logic                    video_on,
   input  logic [9:0]              hcount,
   input  logic [9:0]              vcount,
   input  logic [10*NUM_OBJ-1:0]   obj_x,
   input  logic [10*NUM_OBJ-1:0]   obj_y,
   input  logic [NUM_OBJ-1:0]      obj_vis,
   input  logic [NUM_OBJ-1:0]      obj_flash,
   input  logic [12*NUM_OBJ-1:0]   obj_rgb,
   input  logic [9:0]              hole_x,
   input  logic [6:0]              hole_w,
   input  logic [6:0]              bar_level,
   output logic [3:0]              vgaRed,
   output logic [3:0]              vgaGreen,
   output logic [3:0]              vgaBlue,
   output logic                    de_out
);

   localparam int FC_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
   localparam logic [10:0] L_BRD_LO   = 11'(BORDER);
   localparam logic [10:0] L_BRD_HR   = 11'(640 - BORDER);
   localparam logic [10:0] L_BRD_VB   = 11'(480 - BORDER);
   localparam logic [10:0] L_PLAT_TOP = 11'(PLAT_Y);
   localparam logic [10:0] L_PLAT_BOT = 11'(PLAT_Y + PLAT_H);
   localparam logic [10:0] L_BAR_X0   = 11'(BAR_X);
   localparam logic [10:0] L_BAR_X1   = 11'(BAR_X + 16);
   localparam logic [10:0] L_BAR_BASE = 11'(BAR_BASE);

   function automatic logic [6:0] clamp_level(input logic [6:0] lvl);
      return (lvl > 7'd64) ? 7'd64 : lvl;
   endfunction

   logic [10*NUM_OBJ-1:0] r_sh_x, r_sh_y;
   logic [12*NUM_OBJ-1:0] r_sh_rgb;
   logic [NUM_OBJ-1:0]    r_sh_vis, r_sh_flash;
   logic [9:0]            r_sh_hx;
   logic [6:0]            r_sh_hw, r_sh_bar;
   logic [FC_W-1:0]       r_fcnt;
   logic                  r_phase;
   logic [11:0]           w_flash_rgb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_x     <= '0;
         r_sh_y     <= '0;
         r_sh_rgb   <= '0;
         r_sh_vis   <= '0;
         r_sh_flash <= '0;
         r_sh_hx    <= '0;
         r_sh_hw    <= '0;
         r_sh_bar   <= '0;
         r_fcnt     <= '0;
         r_phase    <= 1'b0;
      end else if (frame_tick) begin
         r_sh_x     <= obj_x;
         r_sh_y     <= obj_y;
         r_sh_rgb   <= obj_rgb;
         r_sh_vis   <= obj_vis;
         r_sh_flash <= obj_flash;
         r_sh_hx    <= hole_x;
         r_sh_hw    <= hole_w;
         r_sh_bar   <= clamp_level(bar_level);
         if (r_fcnt == FC_W'(FLASH_FRAMES - 1)) begin
            r_fcnt  <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_fcnt  <= r_fcnt + 1'b1;
         end
      end
   end

`ifdef COMPOSITOR_RAND_FLASH_EN
   logic [7:0] r_lfsr;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_lfsr <= 8'hA5;
      else if (frame_tick) r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
   end
   assign w_flash_rgb = {r_lfsr[7:5], 1'b1, r_lfsr[4:2], 1'b1, r_lfsr[1:0], 2'b11};
`else
   assign w_flash_rgb = 12'h000;
`endif

   // Stage 1: geometry hit flags from the shadow state
   logic [10:0]        w_h, w_v;
   logic [9:0]         w_hole_r;
   logic               w_border, w_plat, w_pit, w_in_hole, w_bar;
   logic [NUM_OBJ-1:0] w_obj_hit;

   assign w_h       = {1'b0, hcount};
   assign w_v       = {1'b0, vcount};
   assign w_hole_r  = r_sh_hx + {3'b000, r_sh_hw};
   assign w_border  = (w_h < L_BRD_LO) || (w_h >= L_BRD_HR) || (w_v < L_BRD_LO) || (w_v >= L_BRD_VB);
   assign w_plat    = (w_v >= L_PLAT_TOP) && (w_v < L_PLAT_BOT);
   assign w_pit     = (w_v >= L_PLAT_BOT) && (w_v < L_BRD_VB);
   assign w_in_hole = (r_sh_hw != 7'd0) &&
                      ((w_hole_r > r_sh_hx) ? ((hcount >= r_sh_hx) && (hcount < w_hole_r))
                                            : ((hcount >= r_sh_hx) || (hcount < w_hole_r)));
   // Written as v + level >= base so an empty bar never underflows
   assign w_bar     = (w_h >= L_BAR_X0) && (w_h < L_BAR_X1) && (w_v < L_BAR_BASE) &&
                      ((w_v + {4'b0000, r_sh_bar}) >= L_BAR_BASE);

   always_comb begin
      w_obj_hit = '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         w_obj_hit[i] = r_sh_vis[i] &&
                        (w_h >= {1'b0, r_sh_x[10*i +: 10]}) &&
                        (w_h <  {1'b0, r_sh_x[10*i +: 10]} + 11'(OBJ_W)) &&
                        (w_v >= {1'b0, r_sh_y[10*i +: 10]}) &&
                        (w_v <  {1'b0, r_sh_y[10*i +: 10]} + 11'(OBJ_H));
      end
   end

   logic               r_border_p1, r_plat_p1, r_pit_p1, r_hole_p1, r_bar_p1, r_vld_p1;
   logic [NUM_OBJ-1:0] r_hit_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_border_p1 <= 1'b0;
         r_plat_p1   <= 1'b0;
         r_pit_p1    <= 1'b0;
         r_hole_p1   <= 1'b0;
         r_bar_p1    <= 1'b0;
         r_hit_p1    <= '0;
         r_vld_p1    <= 1'b0;
      end else begin
         r_border_p1 <= w_border;
         r_plat_p1   <= w_plat;
         r_pit_p1    <= w_pit;
         r_hole_p1   <= w_in_hole;
         r_bar_p1    <= w_bar;
         r_hit_p1    <= w_obj_hit;
         r_vld_p1    <= video_on;
      end
   end

   // Stage 2: priority mux into the output registers
   logic        w_obj_any;
   logic [11:0] w_obj_col, w_pix;

   always_comb begin
      w_obj_any = 1'b0;
      w_obj_col = 12'h000;
      for (int i = NUM_OBJ - 1; i >= 0; i--) begin
         if (r_hit_p1[i]) begin
            w_obj_any = 1'b1;
            w_obj_col = (r_sh_flash[i] && r_phase) ? w_flash_rgb : r_sh_rgb[12*i +: 12];
         end
      end
      w_pix = 12'h000;
      if (!r_vld_p1)                     w_pix = 12'h000;
      else if (r_border_p1)              w_pix = 12'hF00;
      else if (w_obj_any)                w_pix = w_obj_col;
      else if (r_bar_p1)                 w_pix = 12'h0F0;
      else if (r_plat_p1 && !r_hole_p1)  w_pix = 12'h0F0;
      else if (r_pit_p1 && !r_hole_p1)   w_pix = 12'h888;
   end

   logic [11:0] r_rgb_p2;
   logic        r_vld_p2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rgb_p2 <= 12'h000;
         r_vld_p2 <= 1'b0;
      end else begin
         r_rgb_p2 <= w_pix;
         r_vld_p2 <= r_vld_p1;
      end
   end

   assign vgaRed   = r_rgb_p2[11:8];
   assign vgaGreen = r_rgb_p2[7:4];
   assign vgaBlue  = r_rgb_p2[3:0];
   assign de_out   = r_vld_p2;

endmodule
